// File: rtl/alu_mc.sv
// Parametrised multi-cycle ALU: single-cycle arithmetic/logic/shift ops plus
// iterative radix-2 multiply and restoring divide with a HI/LO result pair.
module alu_mc #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  input  logic [4:0]       ALUC,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] RESULT,
  output logic [WIDTH-1:0] HI,
  output logic             BUSY,
  output logic             DONE,
  output logic             ZERO,
  output logic             CARRY,
  output logic             NEGATIVE,
  output logic             OVERFLOW
);

  localparam logic [WIDTH-1:0] MIN_V = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic {S_IDLE, S_EXEC} state_t;

  state_t           r_state;
  logic [SHW-1:0]   r_cnt;
  logic [WIDTH-1:0] r_result, r_hi, r_acc, r_lo, r_md;
  logic             r_busy, r_done, r_zero, r_carry, r_neg, r_ovf;
  logic             r_div, r_qneg, r_rneg, r_dz, r_ovmin;

  function automatic logic [WIDTH-1:0] f_neg_if(input logic [WIDTH-1:0] x, input logic c);
    return c ? -x : x;
  endfunction

  logic             w_sgn;
  logic [WIDTH-1:0] w_a_mag, w_b_mag;
  assign w_sgn   = ALUC[0];
  assign w_a_mag = f_neg_if(A, w_sgn & A[WIDTH-1]);
  assign w_b_mag = f_neg_if(B, w_sgn & B[WIDTH-1]);

  logic [WIDTH:0]          w_add, w_sub, w_srx, w_slx;
  logic [SHW-1:0]          w_sh;
  logic signed [WIDTH-1:0] w_sra;
  logic                    w_lt_s, w_lt_u;
  assign w_add  = {1'b0, A} + {1'b0, B};
  assign w_sub  = {1'b0, A} - {1'b0, B};
  assign w_sh   = A[SHW-1:0];
  // Extra guard bit catches the last bit shifted out; it is 0 for a zero shift.
  assign w_srx  = {B, 1'b0} >> w_sh;
  assign w_slx  = {1'b0, B} << w_sh;
  assign w_sra  = $signed(B) >>> w_sh;
  assign w_lt_s = $signed(A) < $signed(B);
  assign w_lt_u = w_sub[WIDTH];

  logic [WIDTH-1:0] w_sres;
  logic             w_scy, w_cy_en, w_sov, w_ov_en, w_sneg;

  always_comb begin
    w_sres  = '0;
    w_scy   = 1'b0;
    w_cy_en = 1'b0;
    w_sov   = 1'b0;
    w_ov_en = 1'b0;
    case (ALUC[3:0])
      4'b0000: begin w_sres = w_add[WIDTH-1:0]; w_scy = w_add[WIDTH]; w_cy_en = 1'b1; end
      4'b0001: begin w_sres = w_sub[WIDTH-1:0]; w_scy = w_lt_u;       w_cy_en = 1'b1; end
      4'b0010: begin
        w_sres  = w_add[WIDTH-1:0];
        w_sov   = (A[WIDTH-1] ~^ B[WIDTH-1]) & (w_add[WIDTH-1] ^ A[WIDTH-1]);
        w_ov_en = 1'b1;
      end
      4'b0011: begin
        w_sres  = w_sub[WIDTH-1:0];
        w_sov   = (A[WIDTH-1] ^ B[WIDTH-1]) & (w_sub[WIDTH-1] ^ A[WIDTH-1]);
        w_ov_en = 1'b1;
      end
      4'b0100: w_sres = A & B;
      4'b0101: w_sres = A | B;
      4'b0110: w_sres = A ^ B;
      4'b0111: w_sres = ~(A | B);
      4'b1000, 4'b1001: w_sres = B << (WIDTH/2);
      4'b1010: begin w_sres = {{(WIDTH-1){1'b0}}, w_lt_u}; w_scy = w_lt_u; w_cy_en = 1'b1; end
      4'b1011: w_sres = {{(WIDTH-1){1'b0}}, w_lt_s};
      4'b1100: begin w_sres = w_sra;     w_scy = w_srx[0]; w_cy_en = 1'b1; end
      4'b1101: begin w_sres = B >> w_sh; w_scy = w_srx[0]; w_cy_en = 1'b1; end
      default: begin w_sres = B << w_sh; w_scy = w_slx[WIDTH]; w_cy_en = 1'b1; end
    endcase
  end

  assign w_sneg = (ALUC[3:0] == 4'b1011) ? w_lt_s : w_sres[WIDTH-1];

  // One radix-2 step: shift-add for multiply, compare-subtract for divide.
  logic [WIDTH:0]       w_msum, w_rsh, w_diff;
  logic [WIDTH-1:0]     w_acc_nx, w_lo_nx, w_q, w_r;
  logic [2*WIDTH-1:0]   w_prod, w_prod_c;
  logic                 w_last;

  assign w_msum = {1'b0, r_acc} + (r_lo[0] ? {1'b0, r_md} : '0);
  assign w_rsh  = {r_acc, r_lo[WIDTH-1]};
  assign w_diff = w_rsh - {1'b0, r_md};

  always_comb begin
    if (r_div) begin
      w_acc_nx = w_diff[WIDTH] ? w_rsh[WIDTH-1:0] : w_diff[WIDTH-1:0];
      w_lo_nx  = {r_lo[WIDTH-2:0], ~w_diff[WIDTH]};
    end else begin
      w_acc_nx = w_msum[WIDTH:1];
      w_lo_nx  = {w_msum[0], r_lo[WIDTH-1:1]};
    end
  end

  assign w_prod   = {w_acc_nx, w_lo_nx};
  assign w_prod_c = r_qneg ? -w_prod : w_prod;
  assign w_q      = r_dz ? '1 : f_neg_if(w_lo_nx, r_qneg);
  assign w_r      = f_neg_if(w_acc_nx, r_rneg);
  assign w_last   = (r_cnt == SHW'(WIDTH-1));

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_result <= '0;
      r_hi     <= '0;
      r_acc    <= '0;
      r_lo     <= '0;
      r_md     <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_zero   <= 1'b0;
      r_carry  <= 1'b0;
      r_neg    <= 1'b0;
      r_ovf    <= 1'b0;
      r_div    <= 1'b0;
      r_qneg   <= 1'b0;
      r_rneg   <= 1'b0;
      r_dz     <= 1'b0;
      r_ovmin  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (START && ALUC[4]) begin
            r_state <= S_EXEC;
            r_busy  <= 1'b1;
            r_cnt   <= '0;
            r_div   <= ALUC[1];
            r_acc   <= '0;
            r_lo    <= ALUC[1] ? w_a_mag : w_b_mag;
            r_md    <= ALUC[1] ? w_b_mag : w_a_mag;
            r_qneg  <= w_sgn & (A[WIDTH-1] ^ B[WIDTH-1]);
            r_rneg  <= w_sgn & A[WIDTH-1];
            r_dz    <= ALUC[1] & (B == '0);
            r_ovmin <= ALUC[1] & w_sgn & (A == MIN_V) & (B == '1);
          end else if (START) begin
            r_result <= w_sres;
            r_zero   <= (w_sres == '0);
            r_neg    <= w_sneg;
            r_done   <= 1'b1;
            if (w_cy_en) r_carry <= w_scy;
            if (w_ov_en) r_ovf   <= w_sov;
          end
        end
        S_EXEC: begin
          r_acc <= w_acc_nx;
          r_lo  <= w_lo_nx;
          r_cnt <= r_cnt + 1'b1;
          if (w_last) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            if (r_div) begin
              r_result <= w_q;
              r_hi     <= w_r;
              r_zero   <= (w_q == '0);
              r_neg    <= w_q[WIDTH-1];
              r_ovf    <= r_dz | r_ovmin;
            end else begin
              r_result <= w_prod_c[WIDTH-1:0];
              r_hi     <= w_prod_c[2*WIDTH-1:WIDTH];
              r_zero   <= (w_prod_c == '0);
              r_neg    <= w_prod_c[2*WIDTH-1];
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign RESULT   = r_result;
  assign HI       = r_hi;
  assign BUSY     = r_busy;
  assign DONE     = r_done;
  assign ZERO     = r_zero;
  assign CARRY    = r_carry;
  assign NEGATIVE = r_neg;
  assign OVERFLOW = r_ovf;

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc at WIDTH=32 and WIDTH=8 against an arithmetic reference model.
module tb_alu_mc;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic        s32_start = 1'b0;
  logic [4:0]  s32_aluc = '0;
  logic [31:0] s32_a = '0, s32_b = '0;
  logic [31:0] o32_res, o32_hi;
  logic        o32_busy, o32_done, o32_z, o32_c, o32_n, o32_v;

  logic        s8_start = 1'b0;
  logic [4:0]  s8_aluc = '0;
  logic [7:0]  s8_a = '0, s8_b = '0;
  logic [7:0]  o8_res, o8_hi;
  logic        o8_busy, o8_done, o8_z, o8_c, o8_n, o8_v;

  alu_mc #(.WIDTH(32)) dut32 (
    .CLK(clk), .RST_N(rst_n), .START(s32_start), .ALUC(s32_aluc), .A(s32_a), .B(s32_b),
    .RESULT(o32_res), .HI(o32_hi), .BUSY(o32_busy), .DONE(o32_done),
    .ZERO(o32_z), .CARRY(o32_c), .NEGATIVE(o32_n), .OVERFLOW(o32_v));

  alu_mc #(.WIDTH(8)) dut8 (
    .CLK(clk), .RST_N(rst_n), .START(s8_start), .ALUC(s8_aluc), .A(s8_a), .B(s8_b),
    .RESULT(o8_res), .HI(o8_hi), .BUSY(o8_busy), .DONE(o8_done),
    .ZERO(o8_z), .CARRY(o8_c), .NEGATIVE(o8_n), .OVERFLOW(o8_v));

  int n_vec = 0;
  int n_err = 0;

  // Reference state: HI and flags {Z,C,N,V} persist between operations.
  logic [63:0] m32_hi = '0, m8_hi = '0;
  logic [3:0]  m32_fl = '0, m8_fl = '0;

  function automatic longint sx(input int w, input logic [63:0] x);
    logic [63:0] m;
    longint t;
    m = (64'd1 << w) - 64'd1;
    x = x & m;
    t = longint'(x);
    if (x[w-1]) t = t - (longint'(1) << w);
    return t;
  endfunction

  function automatic void model(input int w, input logic [4:0] op, input logic [63:0] a,
                                input logic [63:0] b, inout logic [63:0] hi,
                                inout logic [3:0] fl, output logic [63:0] res);
    logic [63:0] mask, mask2, s, p;
    logic z, c, n, v;
    longint t, q, r, lim;
    int sh;
    mask = (64'd1 << w) - 64'd1;
    mask2 = (64'd1 << (2 * w)) - 64'd1;
    lim = longint'(1) << (w - 1);
    sh = int'(a[5:0]) & (w - 1);
    {z, c, n, v} = fl;
    res = '0;
    if (!op[4]) begin
      case (op[3:0])
        4'd0: begin s = a + b; res = s & mask; c = s[w]; end
        4'd1: begin res = (a - b) & mask; c = (a < b); end
        4'd2: begin res = (a + b) & mask; t = sx(w, a) + sx(w, b); v = (t >= lim) || (t < -lim); end
        4'd3: begin res = (a - b) & mask; t = sx(w, a) - sx(w, b); v = (t >= lim) || (t < -lim); end
        4'd4: res = a & b;
        4'd5: res = a | b;
        4'd6: res = a ^ b;
        4'd7: res = ~(a | b) & mask;
        4'd8, 4'd9: res = (b << (w / 2)) & mask;
        4'd10: begin res = {63'd0, a < b}; c = res[0]; end
        4'd11: res = {63'd0, sx(w, a) < sx(w, b)};
        4'd12: begin t = sx(w, b) >>> sh; res = t; res = res & mask; c = (sh != 0) ? b[sh-1] : 1'b0; end
        4'd13: begin res = b >> sh; c = (sh != 0) ? b[sh-1] : 1'b0; end
        default: begin res = (b << sh) & mask; c = (sh != 0) ? b[w-sh] : 1'b0; end
      endcase
      z = (res == 64'd0);
      n = (op[3:0] == 4'd11) ? res[0] : res[w-1];
    end else if (!op[1]) begin
      if (op[0]) begin t = sx(w, a) * sx(w, b); p = t; end
      else p = a * b;
      p = p & mask2;
      res = p & mask;
      hi = (p >> w) & mask;
      z = (p == 64'd0);
      n = hi[w-1];
    end else begin
      if (b == 64'd0) begin
        res = mask; hi = a; v = 1'b1;
      end else if (op[0] && sx(w, a) == -lim && sx(w, b) == -1) begin
        res = 64'd1 << (w - 1); hi = 64'd0; v = 1'b1;
      end else if (op[0]) begin
        q = sx(w, a) / sx(w, b);
        r = sx(w, a) % sx(w, b);
        res = q; res = res & mask;
        hi = r; hi = hi & mask;
        v = 1'b0;
      end else begin
        res = a / b; hi = a % b; v = 1'b0;
      end
      z = (res == 64'd0);
      n = res[w-1];
    end
    fl = {z, c, n, v};
  endfunction

  task automatic run32(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int lat);
    @(negedge clk);
    s32_aluc = op; s32_a = a; s32_b = b; s32_start = 1'b1;
    @(posedge clk); #1;
    s32_start = 1'b0;
    lat = 0;
    while (!o32_done && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run8(input logic [4:0] op, input logic [7:0] a, input logic [7:0] b,
                      output int lat);
    @(negedge clk);
    s8_aluc = op; s8_a = a; s8_b = b; s8_start = 1'b1;
    @(posedge clk); #1;
    s8_start = 1'b0;
    lat = 0;
    while (!o8_done && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  function automatic logic [31:0] pick32();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 40));
      default: return 32'($urandom());
    endcase
  endfunction

  function automatic logic [7:0] pick8();
    case ($urandom_range(0, 5))
      0: return 8'h0;
      1: return 8'h80;
      2: return 8'hFF;
      3: return 8'($urandom_range(0, 9));
      default: return 8'($urandom());
    endcase
  endfunction

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #1;
    n_vec++;
    if ({o32_res, o32_hi, o32_busy, o32_done, o32_z, o32_c, o32_n, o32_v} !== 70'd0) begin
      n_err++;
      $display("FAIL reset32: got res=%h hi=%h busy=%b done=%b zcnv=%b, want all 0",
               o32_res, o32_hi, o32_busy, o32_done, {o32_z, o32_c, o32_n, o32_v});
    end
    n_vec++;
    if ({o8_res, o8_hi, o8_busy, o8_done, o8_z, o8_c, o8_n, o8_v} !== 22'd0) begin
      n_err++;
      $display("FAIL reset8: got res=%h hi=%h busy=%b done=%b zcnv=%b, want all 0",
               o8_res, o8_hi, o8_busy, o8_done, {o8_z, o8_c, o8_n, o8_v});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m32_hi = '0; m32_fl = '0; m8_hi = '0; m8_fl = '0;
  endtask

  task automatic test_carry_hold();
    int lat;
    logic [63:0] er;
    run32(5'b00000, 32'hFFFF_FFFF, 32'h1, lat);
    model(32, 5'b00000, 64'hFFFF_FFFF, 64'h1, m32_hi, m32_fl, er);
    n_vec++;
    if (o32_res !== 32'h0 || o32_z !== 1'b1 || o32_c !== 1'b1 || lat != 0 ||
        {o32_z, o32_c, o32_n, o32_v} !== m32_fl || o32_hi !== m32_hi[31:0]) begin
      n_err++;
      $display("FAIL addu_carry: got res=%h zcnv=%b lat=%0d, want res=00000000 zcnv=%b lat=0",
               o32_res, {o32_z, o32_c, o32_n, o32_v}, lat, m32_fl);
    end
    run32(5'b00100, 32'hF0F0_1234, 32'h0FF0_FFFF, lat);
    model(32, 5'b00100, 64'hF0F0_1234, 64'h0FF0_FFFF, m32_hi, m32_fl, er);
    n_vec++;
    if (o32_res !== 32'h00F0_1234 || o32_c !== 1'b1 || o32_res !== er[31:0] ||
        {o32_z, o32_c, o32_n, o32_v} !== m32_fl || lat != 0) begin
      n_err++;
      $display("FAIL and_carry_hold: got res=%h zcnv=%b, want res=%h zcnv=%b",
               o32_res, {o32_z, o32_c, o32_n, o32_v}, er[31:0], m32_fl);
    end
  endtask

  task automatic test_add_ovf();
    int lat;
    logic [63:0] er;
    run32(5'b00010, 32'h7FFF_FFFF, 32'h1, lat);
    model(32, 5'b00010, 64'h7FFF_FFFF, 64'h1, m32_hi, m32_fl, er);
    n_vec++;
    if (o32_res !== 32'h8000_0000 || o32_v !== 1'b1 || o32_n !== 1'b1 || o32_c !== 1'b1 ||
        {o32_z, o32_c, o32_n, o32_v} !== m32_fl || lat != 0) begin
      n_err++;
      $display("FAIL add_ovf: got res=%h zcnv=%b, want res=80000000 zcnv=%b",
               o32_res, {o32_z, o32_c, o32_n, o32_v}, m32_fl);
    end
  endtask

  task automatic test_mult();
    int lat;
    logic [63:0] er;
    @(negedge clk);
    s32_aluc = 5'b10001; s32_a = 32'hFFFF_FFFE; s32_b = 32'h3; s32_start = 1'b1;
    @(posedge clk); #1;
    s32_start = 1'b0;
    n_vec++;
    if (o32_busy !== 1'b1 || o32_done !== 1'b0) begin
      n_err++;
      $display("FAIL mult_busy: got busy=%b done=%b, want busy=1 done=0", o32_busy, o32_done);
    end
    lat = 0;
    while (!o32_done && lat < 100) begin
      @(negedge clk);
      if (lat == 5) begin
        s32_aluc = 5'b00000; s32_a = 32'h1; s32_b = 32'h1; s32_start = 1'b1;
      end else s32_start = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    s32_start = 1'b0;
    model(32, 5'b10001, 64'hFFFF_FFFE, 64'h3, m32_hi, m32_fl, er);
    n_vec++;
    if (o32_hi !== 32'hFFFF_FFFF || o32_res !== 32'hFFFF_FFFA || o32_n !== 1'b1 ||
        {o32_z, o32_c, o32_n, o32_v} !== m32_fl || lat != 32 || o32_busy !== 1'b0) begin
      n_err++;
      $display("FAIL mult_signed: got hi=%h res=%h zcnv=%b lat=%0d busy=%b, want hi=ffffffff res=fffffffa zcnv=%b lat=32 busy=0",
               o32_hi, o32_res, {o32_z, o32_c, o32_n, o32_v}, lat, o32_busy, m32_fl);
    end
  endtask

  task automatic test_div();
    logic [4:0]  ops [3] = '{5'b10011, 5'b10010, 5'b11111};
    logic [31:0] as  [3] = '{32'hFFFF_FFF9, 32'h0000_1234, 32'h8000_0000};
    logic [31:0] bs  [3] = '{32'h2, 32'h0, 32'hFFFF_FFFF};
    logic [31:0] eq  [3] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h8000_0000};
    logic [31:0] eh  [3] = '{32'hFFFF_FFFF, 32'h0000_1234, 32'h0};
    logic        ev  [3] = '{1'b0, 1'b1, 1'b1};
    int lat;
    logic [63:0] er;
    for (int i = 0; i < 3; i++) begin
      run32(ops[i], as[i], bs[i], lat);
      model(32, ops[i], {32'd0, as[i]}, {32'd0, bs[i]}, m32_hi, m32_fl, er);
      n_vec++;
      if (o32_res !== eq[i] || o32_hi !== eh[i] || o32_v !== ev[i] || lat != 32 ||
          {o32_z, o32_c, o32_n, o32_v} !== m32_fl) begin
        n_err++;
        $display("FAIL div_%0d: got res=%h hi=%h zcnv=%b lat=%0d, want res=%h hi=%h zcnv=%b lat=32",
                 i, o32_res, o32_hi, {o32_z, o32_c, o32_n, o32_v}, lat, eq[i], eh[i], m32_fl);
      end
    end
  endtask

  task automatic test_random32(input int n);
    int lat;
    logic [4:0] op;
    logic [31:0] a, b;
    logic [63:0] er;
    for (int i = 0; i < n; i++) begin
      op = 5'($urandom_range(0, 31));
      a = pick32();
      b = pick32();
      run32(op, a, b, lat);
      model(32, op, {32'd0, a}, {32'd0, b}, m32_hi, m32_fl, er);
      n_vec++;
      if (o32_res !== er[31:0] || o32_hi !== m32_hi[31:0] ||
          {o32_z, o32_c, o32_n, o32_v} !== m32_fl || lat != (op[4] ? 32 : 0)) begin
        n_err++;
        $display("FAIL rand32 op=%b a=%h b=%h: got res=%h hi=%h zcnv=%b lat=%0d, want res=%h hi=%h zcnv=%b lat=%0d",
                 op, a, b, o32_res, o32_hi, {o32_z, o32_c, o32_n, o32_v}, lat,
                 er[31:0], m32_hi[31:0], m32_fl, op[4] ? 32 : 0);
      end
    end
  endtask

  task automatic test_w8();
    int lat;
    logic [63:0] er;
    run8(5'b01110, 8'h01, 8'h81, lat);
    model(8, 5'b01110, 64'h01, 64'h81, m8_hi, m8_fl, er);
    n_vec++;
    if (o8_res !== 8'h02 || o8_c !== 1'b1 || {o8_z, o8_c, o8_n, o8_v} !== m8_fl || lat != 0) begin
      n_err++;
      $display("FAIL w8_sll: got res=%h zcnv=%b, want res=02 zcnv=%b", o8_res, {o8_z, o8_c, o8_n, o8_v}, m8_fl);
    end
    run8(5'b01100, 8'h07, 8'h80, lat);
    model(8, 5'b01100, 64'h07, 64'h80, m8_hi, m8_fl, er);
    n_vec++;
    if (o8_res !== 8'hFF || {o8_z, o8_c, o8_n, o8_v} !== m8_fl || lat != 0) begin
      n_err++;
      $display("FAIL w8_sra: got res=%h zcnv=%b, want res=ff zcnv=%b", o8_res, {o8_z, o8_c, o8_n, o8_v}, m8_fl);
    end
    run8(5'b10000, 8'hFF, 8'hFF, lat);
    model(8, 5'b10000, 64'hFF, 64'hFF, m8_hi, m8_fl, er);
    n_vec++;
    if (o8_hi !== 8'hFE || o8_res !== 8'h01 || lat != 8 || o8_done !== 1'b1 ||
        {o8_z, o8_c, o8_n, o8_v} !== m8_fl) begin
      n_err++;
      $display("FAIL w8_multu: got hi=%h res=%h lat=%0d done=%b, want hi=fe res=01 lat=8 done=1",
               o8_hi, o8_res, lat, o8_done);
    end
    run8(5'b00000, 8'h03, 8'h04, lat);
    model(8, 5'b00000, 64'h03, 64'h04, m8_hi, m8_fl, er);
    n_vec++;
    if (o8_res !== 8'h07 || o8_hi !== 8'hFE || lat != 0 || {o8_z, o8_c, o8_n, o8_v} !== m8_fl) begin
      n_err++;
      $display("FAIL w8_start_in_done: got res=%h hi=%h lat=%0d, want res=07 hi=fe lat=0",
               o8_res, o8_hi, lat);
    end
  endtask

  task automatic test_random8(input int n);
    int lat;
    logic [4:0] op;
    logic [7:0] a, b;
    logic [63:0] er;
    for (int i = 0; i < n; i++) begin
      op = 5'($urandom_range(0, 31));
      a = pick8();
      b = pick8();
      run8(op, a, b, lat);
      model(8, op, {56'd0, a}, {56'd0, b}, m8_hi, m8_fl, er);
      n_vec++;
      if (o8_res !== er[7:0] || o8_hi !== m8_hi[7:0] ||
          {o8_z, o8_c, o8_n, o8_v} !== m8_fl || lat != (op[4] ? 8 : 0)) begin
        n_err++;
        $display("FAIL rand8 op=%b a=%h b=%h: got res=%h hi=%h zcnv=%b lat=%0d, want res=%h hi=%h zcnv=%b lat=%0d",
                 op, a, b, o8_res, o8_hi, {o8_z, o8_c, o8_n, o8_v}, lat,
                 er[7:0], m8_hi[7:0], m8_fl, op[4] ? 8 : 0);
      end
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    logic [63:0] er;
    run32(5'b00110, 32'hDEAD_BEEF, 32'h1234_5678, lat);
    @(negedge clk);
    s32_aluc = 5'b10001; s32_a = 32'h8765_4321; s32_b = 32'hFFFF_0123; s32_start = 1'b1;
    @(posedge clk); #1;
    s32_start = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    n_vec++;
    if (o32_busy !== 1'b1) begin
      n_err++;
      $display("FAIL midop_busy: got busy=%b, want 1", o32_busy);
    end
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({o32_res, o32_hi, o32_busy, o32_done, o32_z, o32_c, o32_n, o32_v} !== 70'd0) begin
      n_err++;
      $display("FAIL midop_reset: got res=%h hi=%h busy=%b done=%b zcnv=%b, want all 0",
               o32_res, o32_hi, o32_busy, o32_done, {o32_z, o32_c, o32_n, o32_v});
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    m32_hi = '0; m32_fl = '0; m8_hi = '0; m8_fl = '0;
    @(posedge clk); #1;
    n_vec++;
    if (o32_busy !== 1'b0 || o32_done !== 1'b0 || o32_res !== 32'h0) begin
      n_err++;
      $display("FAIL midop_aborted: got busy=%b done=%b res=%h, want 0 0 00000000",
               o32_busy, o32_done, o32_res);
    end
    run32(5'b00000, 32'h5, 32'h6, lat);
    model(32, 5'b00000, 64'h5, 64'h6, m32_hi, m32_fl, er);
    n_vec++;
    if (o32_res !== 32'd11 || o32_hi !== 32'h0 || {o32_z, o32_c, o32_n, o32_v} !== m32_fl || lat != 0) begin
      n_err++;
      $display("FAIL after_reset_addu: got res=%h hi=%h zcnv=%b lat=%0d, want res=0000000b hi=0 zcnv=%b lat=0",
               o32_res, o32_hi, {o32_z, o32_c, o32_n, o32_v}, lat, m32_fl);
    end
  endtask

  initial begin
    test_reset();
    test_carry_hold();
    test_add_ovf();
    test_mult();
    test_div();
    test_random32(100);
    test_w8();
    test_random8(150);
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu_mc.md
# alu_mc

Parametrised multi-cycle ALU for the CPU datapath and the successor to the single-cycle 32-bit ALU. It adds three things: a generic WIDTH, an iterative radix-2 multiplier and divider with a HI/LO result pair, and a START/BUSY/DONE handshake. Status flags are held in registers, so flags an operation does not define keep their previous value through clocked storage rather than latches. It sits between the register-file read stage and write-back, and the control unit stalls on BUSY.

## Interface

- WIDTH, 32, datapath width; must be a power of two, at least 8.
- SHW, $clog2(WIDTH), derived shift-amount width; do not override.

- CLK  in  1  rising-edge clock.
- RST_N  in  1  asynchronous active-low reset.
- START  in  1  request; accepted on a rising edge when START=1 and BUSY=0.
- ALUC  in  5  opcode, sampled on the accept edge.
- A  in  WIDTH  operand A; A[SHW-1:0] is the shift amount; sampled on accept.
- B  in  WIDTH  operand B; sampled on accept.
- RESULT  out  WIDTH  registered result; LO for MUL/DIV.
- HI  out  WIDTH  registered product high half or remainder; unchanged by single-cycle operations.
- BUSY  out  1  multi-cycle operation in progress.
- DONE  out  1  one-cycle pulse; RESULT, HI and the flags are valid in this cycle.
- ZERO, CARRY, NEGATIVE, OVERFLOW  out  1 each  registered flags.

## Operation

- Single-cycle ops (ALUC[4]=0):
  - 0000 ADDU, 0001 SUBU, 0010 ADD, 0011 SUB.
  - 0100 AND, 0101 OR, 0110 XOR, 0111 NOR.
  - 100x LUI: B << WIDTH/2.
  - 1010 SLTU, 1011 SLT.
  - 1100 SRA, 1101 SRL, 111x SLL. Each shifts B by A[SHW-1:0].
- Multi-cycle ops (ALUC[4]=1, ALUC[3:2] ignored):
  - xx00 MULTU, xx01 MULT, xx10 DIVU, xx11 DIV.
- ZERO and NEGATIVE update on every completed operation:
  - Default: ZERO = (RESULT==0), NEGATIVE = RESULT[WIDTH-1].
  - SLT: NEGATIVE = the SLT outcome.
  - MUL: ZERO = (the full 2·WIDTH product == 0), NEGATIVE = HI[WIDTH-1].
- CARRY updates only on ADDU, SUBU, SLTU and the shifts; it holds on every other op.
  - ADDU: carry-out. SUBU: borrow, i.e. A<B unsigned. SLTU: the result bit.
  - Shifts: the last bit shifted out; 0 when the shift amount is 0.
- OVERFLOW updates only on ADD, SUB, DIVU and DIV; it holds on every other op.
  - ADD/SUB: signed overflow.
  - DIV/DIVU: 1 on divide-by-zero or on signed MIN/−1, otherwise 0.
- MUL: shift-add over WIDTH iterations. Signed operands are converted to magnitudes and the product sign is corrected on the final edge.
- DIV: restoring division over WIDTH iterations on magnitudes. Quotient goes to RESULT, remainder to HI.
  - Signed: quotient truncates toward zero; the remainder takes the sign of the dividend.
  - B=0: RESULT = all ones, HI = A, OVERFLOW = 1.
  - DIV of MIN/−1: RESULT = MIN, HI = 0, OVERFLOW = 1.
- FSM states:
  - IDLE → EXEC on accept of a multi-cycle op.
  - EXEC runs the iteration counter from 0 to WIDTH−1. On count WIDTH−1 it writes RESULT, HI and the flags, pulses DONE, and returns to IDLE.
  - A single-cycle op is accepted in IDLE and completes on the same edge; the FSM stays in IDLE.

## Timing

- Reset (asynchronous, at any time, including mid-EXEC): the op is aborted.
  - FSM goes to IDLE and the counter to 0.
  - RESULT, HI, BUSY, DONE and all four flags go to 0.
- Single-cycle op, accepted on edge e0:
  - Outputs update on e0 and DONE=1 for the cycle after e0.
  - BUSY stays 0, so back-to-back accepts every cycle are legal.
- Multi-cycle op, accepted on edge e0:
  - BUSY=1 from e0 to eWIDTH.
  - Iterations run on edges e1..eWIDTH.
  - Outputs update on eWIDTH; DONE=1 and BUSY=0 in the cycle after eWIDTH.
  - Latency is exactly WIDTH cycles.
- START while BUSY=1 is ignored; it is neither queued nor allowed to corrupt the operation in progress.
- START in the DONE cycle is accepted.
- Outputs are stable between DONE pulses.

## Test plan

- Reset mid-op: RST_N low for 2 cycles during MULT at iteration 10 → BUSY=0, DONE=0, RESULT=HI=0 and all flags 0, asynchronously (no clock edge needed).
- CARRY hold: ADDU FFFFFFFF+00000001 → RESULT=0, ZERO=1, CARRY=1, DONE one cycle after accept. A following AND keeps CARRY=1.
- Signed add overflow: ADD 7FFFFFFF+00000001 → RESULT=80000000, OVERFLOW=1, NEGATIVE=1, CARRY unchanged.
- Signed multiply: MULT FFFFFFFE×00000003 → HI=FFFFFFFF, RESULT=FFFFFFFA, NEGATIVE=1.
  - DONE exactly 32 cycles after accept.
  - START pulsed at cycle 5 has no effect.
- Divide:
  - DIV FFFFFFF9/00000002 → RESULT=FFFFFFFD, HI=FFFFFFFF, OVERFLOW=0.
  - DIVU 00001234/0 → RESULT=FFFFFFFF, HI=00001234, OVERFLOW=1.
- WIDTH=8:
  - SLL by A=1 on B=81 → 02, CARRY=1.
  - SRA by A=7 on B=80 → FF.
  - MULTU FF×FF → HI=FE, RESULT=01, DONE after 8 cycles.
  - START in the DONE cycle is accepted.
